wishbone_rr_arbiter: RTL and testbench
======================================

Name: wishbone_rr_arbiter

Overview:
Parametrised N-manager to 1-subordinate Wishbone classic arbiter. It is the successor to the fixed-priority 32-bit arbiter.
- Grants are round-robin (fair) and registered; no combinational request-to-bus path.
- Ownership is held for the whole CYC window, so multi-beat block transfers are supported.
- Sits between the CPU, DMA and peripheral managers and the shared subordinate-side interconnect.

Parameters:
NUM_MANAGERS, 6, number of requesting managers (2..16).
ADDR_W, 32, address width.
DATA_W, 32, data width (multiple of 8).
SEL_W, DATA_W/8, byte-select width (derived, not overridden).
TIMEOUT_CYC, 256, cycles without ACK before an error (used only with the optional feature).

Ports:
CLK  in  1  clock.
nRST  in  1  asynchronous active-low reset.
A_ADR_I  in  NUM_MANAGERS x ADDR_W  manager addresses.
A_DAT_I  in  NUM_MANAGERS x DATA_W  manager write data.
A_SEL_I  in  NUM_MANAGERS x SEL_W  manager byte selects.
A_WE_I  in  NUM_MANAGERS  manager write enables.
A_STB_I  in  NUM_MANAGERS  manager strobes.
A_CYC_I  in  NUM_MANAGERS  manager cycle requests.
A_DAT_O  out  NUM_MANAGERS x DATA_W  read data to managers.
A_ACK_O  out  NUM_MANAGERS  acks to managers.
A_ERR_O  out  NUM_MANAGERS  error terminations to managers.
DAT_I  in  DATA_W  subordinate read data.
ACK_I  in  1  subordinate ack.
ADR_O  out  ADDR_W  to subordinate.
DAT_O  out  DATA_W  to subordinate.
SEL_O  out  SEL_W  to subordinate.
WE_O  out  1  to subordinate.
STB_O  out  1  to subordinate.
CYC_O  out  1  to subordinate.
GNT_O  out  NUM_MANAGERS  one-hot current owner, 0 when idle.

Behaviour:
- Clocking and reset: one clock CLK; reset nRST asynchronous active-low.
- Reset values:
  - state = IDLE; GNT_O = 0.
  - Round-robin pointer rr_ptr = 0.
  - Timeout counter = 0.
  - All subordinate-side outputs and all A_* outputs are 0.
- States:
  - IDLE to GRANT when any A_CYC_I bit is set. The winner is the first requester at or after rr_ptr, searching upward with wrap to 0. The winner is registered into GNT_O.
  - GRANT to IDLE when the owner's A_CYC_I falls.
  - GRANT to IDLE on timeout error (optional feature only).
  - On GRANT exit, rr_ptr = owner+1, wrapping NUM_MANAGERS-1 to 0.
- Latency: a request sampled at edge n gives GNT_O and driven subordinate outputs after edge n. No bus activity occurs in the IDLE cycle.
- IDLE gap: one mandatory IDLE cycle between consecutive grants, even if requests are pending. This gives a clean CYC_O drop between owners.
- In GRANT, combinational pass-through:
  - ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O come from the owner.
  - A_DAT_O[owner] = DAT_I; A_ACK_O[owner] = ACK_I & A_STB_I[owner].
  - Non-owners see A_DAT_O, A_ACK_O and A_ERR_O all 0.
- Multi-beat transfers: each ACK completes one beat. Ownership persists until the owner's CYC drops, so block transfers are never interleaved.
- ACK_I while IDLE, or while the owner's STB is low, is ignored and not forwarded.
- Owner dropping CYC in the same cycle as ACK_I: the ack is forwarded if STB is still high, and the next state is IDLE.
- Requests from non-owners are held pending; they are not latched.
- A requester dropping CYC before being granted is forgotten.
- Reset mid-transfer: all outputs go to 0 immediately (asynchronous) and rr_ptr returns to 0.

Optional Feature:
Macro WB_ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to GRANT and on each forwarded ACK, and increments each GRANT cycle with STB_O high.
  - At count TIMEOUT_CYC-1 with no ACK_I, A_ERR_O[owner] pulses for one cycle, CYC_O is forced 0 in that cycle, and the next state is IDLE.
  - ACK_I in the timeout cycle wins; no error is raised.
- Undefined: there is no counter, A_ERR_O is constant 0, and GRANT lasts indefinitely.

Decomposition:
- Package wb_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the default width localparams;
  - the function clog2-based index width.
- Sub-module rr_priority_picker: combinational. Inputs are a request vector and a pointer; outputs are a one-hot grant and a valid flag. Parametrised by N.

Test Plan:
- Single request: reset, then A_CYC_I=6'b000100 with STB, ACK_I after 2 cycles -> GNT_O=000100 one cycle after the request; ADR_O matches manager 2; A_ACK_O=000100 for exactly 1 cycle.
- Round-robin fairness: all 6 managers request continuously, each single-beat -> grant order 0,1,2,3,4,5,0 with one IDLE cycle between each grant.
- Burst hold: manager 1 does 4 beats under one CYC while manager 0 requests -> 4 acks to manager 1 only; manager 0 is granted after manager 1 drops CYC.
- Pointer wrap: rr_ptr=5 after manager 4 releases, requests 000011 -> manager 0 is granted, then manager 1.
- Timeout (macro on, TIMEOUT_CYC=8): no ACK_I -> A_ERR_O[owner]=1 on the 8th STB cycle, then IDLE. Macro off: grant is held for 100+ cycles and A_ERR_O stays 0.
- Async reset mid-burst: nRST low during a GRANT beat -> all outputs are 0 before the next edge; after release a fresh request is granted starting from manager 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types, default widths and helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_NUM_MANAGERS = 6;
    localparam int unsigned DEF_ADDR_W       = 32;
    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_TIMEOUT_CYC  = 256;

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping to 0.
module rr_priority_picker
    import wb_arb_pkg::*;
#(
    parameter int unsigned N = DEF_NUM_MANAGERS,
    localparam int unsigned PTR_W = idx_w(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic             o_valid
);

    logic [PTR_W-1:0] w_idx;

    // Walk the request vector starting at the pointer and keep the first hit.
    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = PTR_W'((32'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// N-manager to 1-subordinate Wishbone classic arbiter with registered round-robin grants.
// Ownership lasts for the owner's whole CYC window; one IDLE cycle separates owners.
// Optional build macro WB_ARB_TIMEOUT_EN adds a no-ACK watchdog that error-terminates the owner.
module wishbone_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MANAGERS = DEF_NUM_MANAGERS,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    localparam int unsigned SEL_W       = DATA_W / 8
) (
    input  logic                                 CLK,
    input  logic                                 nRST,
    input  logic [NUM_MANAGERS-1:0][ADDR_W-1:0]  A_ADR_I,
    input  logic [NUM_MANAGERS-1:0][DATA_W-1:0]  A_DAT_I,
    input  logic [NUM_MANAGERS-1:0][SEL_W-1:0]   A_SEL_I,
    input  logic [NUM_MANAGERS-1:0]              A_WE_I,
    input  logic [NUM_MANAGERS-1:0]              A_STB_I,
    input  logic [NUM_MANAGERS-1:0]              A_CYC_I,
    output logic [NUM_MANAGERS-1:0][DATA_W-1:0]  A_DAT_O,
    output logic [NUM_MANAGERS-1:0]              A_ACK_O,
    output logic [NUM_MANAGERS-1:0]              A_ERR_O,
    input  logic [DATA_W-1:0]                    DAT_I,
    input  logic                                 ACK_I,
    output logic [ADDR_W-1:0]                    ADR_O,
    output logic [DATA_W-1:0]                    DAT_O,
    output logic [SEL_W-1:0]                     SEL_O,
    output logic                                 WE_O,
    output logic                                 STB_O,
    output logic                                 CYC_O,
    output logic [NUM_MANAGERS-1:0]              GNT_O
);

    localparam int unsigned IW = idx_w(NUM_MANAGERS);

    arb_state_e              r_state, w_state_nxt;
    logic [NUM_MANAGERS-1:0] r_gnt, w_gnt_nxt;
    logic [IW-1:0]           r_owner, w_owner_nxt;
    logic [IW-1:0]           r_rr_ptr, w_rr_ptr_nxt;

    logic [NUM_MANAGERS-1:0] w_pick_gnt;
    logic                    w_pick_valid;
    logic [IW-1:0]           w_pick_idx;

    logic                    w_own_cyc;
    logic                    w_own_stb;
    logic                    w_ack_fwd;
    logic                    w_timeout;

    rr_priority_picker #(
        .N (NUM_MANAGERS)
    ) u_picker (
        .i_req   (A_CYC_I),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_pick_gnt),
        .o_valid (w_pick_valid)
    );

    // Encode the picker's one-hot winner into an owner index.
    always_comb begin
        w_pick_idx = '0;
        for (int unsigned i = 0; i < NUM_MANAGERS; i++) begin
            if (w_pick_gnt[i]) begin
                w_pick_idx = IW'(i);
            end
        end
    end

    assign w_own_cyc = (r_state == GRANT) & A_CYC_I[r_owner];
    assign w_own_stb = (r_state == GRANT) & A_STB_I[r_owner];
    assign w_ack_fwd = w_own_stb & ACK_I;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = idx_w(TIMEOUT_CYC) + 1;

    logic [TMO_W-1:0] r_tmo_cnt;

    // An ACK in the final cycle wins over the timeout.
    assign w_timeout = w_own_cyc & w_own_stb & ~ACK_I
                     & (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Count strobed GRANT cycles since grant entry or the last forwarded ACK.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_tmo_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_tmo_cnt <= '0;
        end else if (w_ack_fwd) begin
            r_tmo_cnt <= '0;
        end else if (w_own_stb) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end
`else
    logic w_unused_tmo;

    assign w_timeout    = 1'b0;
    assign w_unused_tmo = ^32'(TIMEOUT_CYC);
`endif

    // Next-state: grant the picker's winner from IDLE, release on CYC drop or timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_pick_gnt;
                    w_owner_nxt = w_pick_idx;
                end
            end
            GRANT: begin
                if (!A_CYC_I[r_owner] || w_timeout) begin
                    w_state_nxt  = IDLE;
                    w_gnt_nxt    = '0;
                    w_rr_ptr_nxt = (r_owner == IW'(NUM_MANAGERS - 1)) ? '0 : r_owner + IW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State, grant, owner and round-robin pointer registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    assign GNT_O = r_gnt;

    // Owner pass-through to the subordinate and response routing back to the owner only.
    always_comb begin
        ADR_O   = '0;
        DAT_O   = '0;
        SEL_O   = '0;
        WE_O    = 1'b0;
        STB_O   = 1'b0;
        CYC_O   = 1'b0;
        A_DAT_O = '0;
        A_ACK_O = '0;
        A_ERR_O = '0;
        if (r_state == GRANT) begin
            ADR_O            = A_ADR_I[r_owner];
            DAT_O            = A_DAT_I[r_owner];
            SEL_O            = A_SEL_I[r_owner];
            WE_O             = A_WE_I[r_owner];
            STB_O            = w_own_stb;
            CYC_O            = w_own_cyc & ~w_timeout;
            A_DAT_O[r_owner] = DAT_I;
            A_ACK_O[r_owner] = w_ack_fwd;
            A_ERR_O[r_owner] = w_timeout;
        end
    end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Directed self-checking bench for wishbone_rr_arbiter (6 managers, 32-bit, TIMEOUT_CYC=8).
module tb_wishbone_rr_arbiter;

    localparam int unsigned N   = 6;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned TMO = 8;

    logic                    CLK;
    logic                    nRST;
    logic [N-1:0][AW-1:0]    A_ADR_I;
    logic [N-1:0][DW-1:0]    A_DAT_I;
    logic [N-1:0][SW-1:0]    A_SEL_I;
    logic [N-1:0]            A_WE_I;
    logic [N-1:0]            A_STB_I;
    logic [N-1:0]            A_CYC_I;
    logic [N-1:0][DW-1:0]    A_DAT_O;
    logic [N-1:0]            A_ACK_O;
    logic [N-1:0]            A_ERR_O;
    logic [DW-1:0]           DAT_I;
    logic                    ACK_I;
    logic [AW-1:0]           ADR_O;
    logic [DW-1:0]           DAT_O;
    logic [SW-1:0]           SEL_O;
    logic                    WE_O;
    logic                    STB_O;
    logic                    CYC_O;
    logic [N-1:0]            GNT_O;

    int n_assert = 0;
    int n_fail   = 0;
    int m;
    logic err_seen;

    wishbone_rr_arbiter #(
        .NUM_MANAGERS (N),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .A_ADR_I (A_ADR_I),
        .A_DAT_I (A_DAT_I),
        .A_SEL_I (A_SEL_I),
        .A_WE_I  (A_WE_I),
        .A_STB_I (A_STB_I),
        .A_CYC_I (A_CYC_I),
        .A_DAT_O (A_DAT_O),
        .A_ACK_O (A_ACK_O),
        .A_ERR_O (A_ERR_O),
        .DAT_I   (DAT_I),
        .ACK_I   (ACK_I),
        .ADR_O   (ADR_O),
        .DAT_O   (DAT_O),
        .SEL_O   (SEL_O),
        .WE_O    (WE_O),
        .STB_O   (STB_O),
        .CYC_O   (CYC_O),
        .GNT_O   (GNT_O)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mgr_adr(input int idx);
        return 32'hA000_0000 + 32'(idx) * 32'd16;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST    = 1'b0;
        A_CYC_I = '0;
        A_STB_I = '0;
        ACK_I   = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        nRST    = 1'b1;
        A_CYC_I = '0;
        A_STB_I = '0;
        ACK_I   = 1'b0;
        DAT_I   = '0;
        for (int i = 0; i < int'(N); i++) begin
            A_ADR_I[i] = mgr_adr(i);
            A_DAT_I[i] = 32'hD000_0000 | 32'(i);
            A_SEL_I[i] = SW'(i + 1);
            A_WE_I[i]  = 1'(i % 2);
        end

        // Reset values, including with requests present while reset is held.
        #1 nRST = 1'b0;
        #1;
        chk("rst_gnt", 64'(GNT_O), 64'h0);
        chk("rst_cyc", 64'(CYC_O), 64'h0);
        chk("rst_adr", 64'(ADR_O), 64'h0);
        chk("rst_ack", 64'(A_ACK_O), 64'h0);
        chk("rst_err", 64'(A_ERR_O), 64'h0);
        A_CYC_I = '1;
        A_STB_I = '1;
        tick();
        #1;
        chk("rst_hold_gnt", 64'(GNT_O), 64'h0);
        A_CYC_I = '0;
        A_STB_I = '0;
        @(negedge CLK);
        nRST = 1'b1;

        // Single request from manager 2; stray ACK in IDLE is ignored.
        tick();
        A_CYC_I = 6'b000100;
        A_STB_I = 6'b000100;
        ACK_I   = 1'b1;
        DAT_I   = 32'h1234_5678;
        #1;
        chk("t1_idle_gnt", 64'(GNT_O), 64'h0);
        chk("t1_idle_cyc", 64'(CYC_O), 64'h0);
        chk("t1_idle_ack", 64'(A_ACK_O), 64'h0);
        tick();
        ACK_I = 1'b0;
        #1;
        chk("t1_gnt", 64'(GNT_O), 64'b000100);
        chk("t1_adr", 64'(ADR_O), 64'hA000_0020);
        chk("t1_sel", 64'(SEL_O), 64'h3);
        chk("t1_we", 64'(WE_O), 64'h0);
        chk("t1_cyc", 64'(CYC_O), 64'h1);
        chk("t1_no_ack", 64'(A_ACK_O), 64'h0);
        tick();
        #1;
        chk("t1_wait_ack", 64'(A_ACK_O), 64'h0);
        tick();
        ACK_I = 1'b1;
        #1;
        chk("t1_ack", 64'(A_ACK_O), 64'b000100);
        chk("t1_rdat", 64'(A_DAT_O[2]), 64'h1234_5678);
        chk("t1_rdat_other", 64'(A_DAT_O[0]), 64'h0);
        tick();
        ACK_I   = 1'b0;
        A_CYC_I = '0;
        A_STB_I = '0;
        #1;
        chk("t1_ack_once", 64'(A_ACK_O), 64'h0);
        chk("t1_gnt_hold", 64'(GNT_O), 64'b000100);
        chk("t1_cyc_drop", 64'(CYC_O), 64'h0);
        tick();
        #1;
        chk("t1_idle", 64'(GNT_O), 64'h0);

        // Round-robin fairness: everyone requests, each owner does one beat.
        do_reset();
        tick();
        A_CYC_I = '1;
        A_STB_I = '1;
        tick();
        for (int k = 0; k < 7; k++) begin
            m     = k % 6;
            ACK_I = 1'b1;
            DAT_I = 32'(k);
            #1;
            chk($sformatf("rr_gnt%0d", k), 64'(GNT_O), 64'(1) << m);
            chk($sformatf("rr_ack%0d", k), 64'(A_ACK_O), 64'(1) << m);
            chk($sformatf("rr_adr%0d", k), 64'(ADR_O), 64'(mgr_adr(m)));
            tick();
            ACK_I      = 1'b0;
            A_CYC_I[m] = 1'b0;
            A_STB_I[m] = 1'b0;
            #1;
            chk($sformatf("rr_drop%0d", k), 64'(CYC_O), 64'h0);
            tick();
            #1;
            chk($sformatf("rr_idle%0d", k), 64'(GNT_O), 64'h0);
            A_CYC_I[m] = 1'b1;
            A_STB_I[m] = 1'b1;
            tick();
        end

        // Burst hold: manager 1 does four beats while manager 0 waits.
        do_reset();
        tick();
        A_CYC_I = 6'b000010;
        A_STB_I = 6'b000010;
        tick();
        A_CYC_I = 6'b000011;
        A_STB_I = 6'b000011;
        #1;
        chk("bh_gnt", 64'(GNT_O), 64'b000010);
        chk("bh_we", 64'(WE_O), 64'h1);
        for (int b = 0; b < 4; b++) begin
            ACK_I = 1'b1;
            DAT_I = 32'hB000_0000 + 32'(b);
            #1;
            chk($sformatf("bh_ack%0d", b), 64'(A_ACK_O), 64'b000010);
            tick();
            ACK_I = 1'b0;
            #1;
            chk($sformatf("bh_gap_ack%0d", b), 64'(A_ACK_O), 64'h0);
            chk($sformatf("bh_gap_gnt%0d", b), 64'(GNT_O), 64'b000010);
            tick();
        end
        A_STB_I[1] = 1'b0;
        ACK_I      = 1'b1;
        #1;
        chk("bh_nostb_ack", 64'(A_ACK_O), 64'h0);
        chk("bh_nostb_stb", 64'(STB_O), 64'h0);
        tick();
        ACK_I      = 1'b0;
        A_CYC_I[1] = 1'b0;
        #1;
        chk("bh_release_cyc", 64'(CYC_O), 64'h0);
        tick();
        #1;
        chk("bh_idle", 64'(GNT_O), 64'h0);
        tick();
        #1;
        chk("bh_next_gnt", 64'(GNT_O), 64'b000001);
        chk("bh_next_adr", 64'(ADR_O), 64'hA000_0000);
        ACK_I = 1'b1;
        #1;
        chk("bh_m0_ack", 64'(A_ACK_O), 64'b000001);
        tick();
        ACK_I   = 1'b0;
        A_CYC_I = '0;
        A_STB_I = '0;
        tick();

        // Pointer wrap: after manager 4 releases, 0 beats 1.
        A_CYC_I = 6'b010000;
        A_STB_I = 6'b010000;
        tick();
        #1;
        chk("pw_gnt4", 64'(GNT_O), 64'b010000);
        ACK_I = 1'b1;
        #1;
        chk("pw_ack4", 64'(A_ACK_O), 64'b010000);
        tick();
        ACK_I   = 1'b0;
        A_CYC_I = 6'b000011;
        A_STB_I = 6'b000011;
        #1;
        chk("pw_hold", 64'(GNT_O), 64'b010000);
        tick();
        #1;
        chk("pw_idle", 64'(GNT_O), 64'h0);
        tick();
        #1;
        chk("pw_wrap", 64'(GNT_O), 64'b000001);
        ACK_I = 1'b1;
        tick();
        ACK_I   = 1'b0;
        A_CYC_I = 6'b000010;
        A_STB_I = 6'b000010;
        tick();
        #1;
        chk("pw_idle2", 64'(GNT_O), 64'h0);
        tick();
        #1;
        chk("pw_next", 64'(GNT_O), 64'b000010);
        ACK_I = 1'b1;
        tick();
        ACK_I   = 1'b0;
        A_CYC_I = '0;
        A_STB_I = '0;
        tick();
        tick();

        // Subordinate never acks manager 3.
        A_CYC_I = 6'b001000;
        A_STB_I = 6'b001000;
        tick();
        #1;
        chk("to_gnt", 64'(GNT_O), 64'b001000);
`ifdef WB_ARB_TIMEOUT_EN
        repeat (6) tick();
        #1;
        chk("to_pre_err", 64'(A_ERR_O), 64'h0);
        chk("to_pre_cyc", 64'(CYC_O), 64'h1);
        tick();
        #1;
        chk("to_err", 64'(A_ERR_O), 64'b001000);
        chk("to_err_cyc", 64'(CYC_O), 64'h0);
        chk("to_err_ack", 64'(A_ACK_O), 64'h0);
        A_CYC_I = '0;
        A_STB_I = '0;
        tick();
        #1;
        chk("to_idle", 64'(GNT_O), 64'h0);
`else
        err_seen = 1'b0;
        for (int c = 0; c < 120; c++) begin
            tick();
            #1;
            if (A_ERR_O != '0) err_seen = 1'b1;
        end
        chk("to_no_err", 64'(err_seen), 64'h0);
        chk("to_held_gnt", 64'(GNT_O), 64'b001000);
        chk("to_held_cyc", 64'(CYC_O), 64'h1);
        A_CYC_I = '0;
        A_STB_I = '0;
        tick();
        tick();
        #1;
        chk("to_idle", 64'(GNT_O), 64'h0);
`endif

        // Asynchronous reset in the middle of a beat, then a fresh grant from manager 0.
        A_CYC_I = 6'b000100;
        A_STB_I = 6'b000100;
        tick();
        #1;
        chk("ar_gnt", 64'(GNT_O), 64'b000100);
        ACK_I = 1'b1;
        DAT_I = 32'hCAFE_F00D;
        #1;
        chk("ar_ack", 64'(A_ACK_O), 64'b000100);
        nRST = 1'b0;
        #1;
        chk("ar_gnt0", 64'(GNT_O), 64'h0);
        chk("ar_cyc0", 64'(CYC_O), 64'h0);
        chk("ar_stb0", 64'(STB_O), 64'h0);
        chk("ar_adr0", 64'(ADR_O), 64'h0);
        chk("ar_ack0", 64'(A_ACK_O), 64'h0);
        chk("ar_dat0", 64'(A_DAT_O[2]), 64'h0);
        A_CYC_I = '0;
        A_STB_I = '0;
        ACK_I   = 1'b0;
        tick();
        nRST    = 1'b1;
        A_CYC_I = 6'b010001;
        A_STB_I = 6'b010001;
        tick();
        #1;
        chk("ar_fresh_gnt", 64'(GNT_O), 64'b000001);
        chk("ar_fresh_adr", 64'(ADR_O), 64'hA000_0000);
        A_CYC_I = '0;
        A_STB_I = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
